// File: rtl/mipi_csi_tx_raw_packer_8b2lane.sv
// Packs 4-pixel groups into the RAW8/RAW10/RAW12 CSI-2 byte stream and emits it as
// 16-bit two-lane words (lane 0 in the low byte), with line-end flush and last marking.
module mipi_csi_tx_raw_packer_8b2lane #(
  parameter int unsigned PIXEL_WIDTH = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [2:0]                 packet_type_i,
  input  logic                       pixel_valid_i,
  output logic                       pixel_ready_o,
  input  logic                       pixel_last_i,
  input  logic [4*PIXEL_WIDTH-1:0]   pixel_i,
  output logic                       output_valid_o,
  input  logic                       output_ready_i,
  output logic [15:0]                output_o,
  output logic [1:0]                 output_keep_o,
  output logic                       output_last_o
);
  localparam int unsigned BUF_BYTES = 8;
  localparam int unsigned BUF_W     = 8 * BUF_BYTES;
  localparam int unsigned FILL_W    = 4;
  localparam int unsigned GRP_W     = 48;

  typedef enum logic [1:0] {IDLE, PACK, FLUSH} state_t;
  typedef enum logic [1:0] {RAW8, RAW10, RAW12} fmt_t;

  state_t             state, state_nx;
  fmt_t               fmt_q, fmt_in, fmt_cur;
  logic [BUF_W-1:0]   data_q, data_nx;
  logic [FILL_W-1:0]  fill, fill_nx, grp_bytes, drain, remain;
  logic [6:0]         drain_sh, app_sh;
  logic [GRP_W-1:0]   grp;
  logic [7:0]         hi [4];
  logic [3:0]         lo [4];
  logic               accept;
  logic               valid_nx, last_nx;
  logic [1:0]         keep_nx;
  logic [15:0]        out_nx;
  logic               unused_pixel_bits;

  assign unused_pixel_bits = ^pixel_i;

  // Upper byte and the four bits below it of each MSB-aligned pixel.
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      hi[p] = pixel_i[p*PIXEL_WIDTH + PIXEL_WIDTH - 1 -: 8];
      lo[p] = pixel_i[p*PIXEL_WIDTH + PIXEL_WIDTH - 9 -: 4];
    end
  end

  always_comb begin
    case (packet_type_i)
      3'h3:    fmt_in = RAW10;
      3'h4:    fmt_in = RAW12;
      default: fmt_in = RAW8;
    endcase
  end

  // The type only matters in IDLE; once a line starts the latched format rules.
  assign fmt_cur = (state == IDLE) ? fmt_in : fmt_q;

  always_comb begin
    grp       = '0;
    grp_bytes = FILL_W'(4);
    case (fmt_cur)
      RAW10: begin
        grp_bytes = FILL_W'(5);
        grp = {8'h00, lo[3][3:2], lo[2][3:2], lo[1][3:2], lo[0][3:2],
               hi[3], hi[2], hi[1], hi[0]};
      end
      RAW12: begin
        grp_bytes = FILL_W'(6);
        grp = {lo[3], lo[2], hi[3], hi[2], lo[1], lo[0], hi[1], hi[0]};
      end
      default: grp = {16'h0000, hi[3], hi[2], hi[1], hi[0]};
    endcase
  end

  assign pixel_ready_o = !reset_i && (state != FLUSH)
                         && (fill <= FILL_W'(BUF_BYTES) - grp_bytes);
  assign accept = pixel_valid_i && pixel_ready_o;

  // Buffer update: pop drained head bytes, append the new group right behind the rest.
  always_comb begin
    drain    = (output_valid_o && output_ready_i)
               ? (output_keep_o[1] ? FILL_W'(2) : FILL_W'(1)) : FILL_W'(0);
    remain   = fill - drain;
    drain_sh = {drain[3:0], 3'b000};
    app_sh   = {remain[3:0], 3'b000};
    fill_nx  = remain + (accept ? grp_bytes : FILL_W'(0));
    data_nx  = (data_q >> drain_sh) | (accept ? (BUF_W'(grp) << app_sh) : BUF_W'(0));
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = pixel_last_i ? FLUSH : PACK;
      PACK:    if (accept && pixel_last_i) state_nx = FLUSH;
      FLUSH:   if (output_valid_o && output_ready_i && output_last_o) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output word for the next cycle, decoded from next-state buffer contents.
  always_comb begin
    valid_nx = (fill_nx >= FILL_W'(2)) || ((state_nx == FLUSH) && (fill_nx == FILL_W'(1)));
    last_nx  = (state_nx == FLUSH) && (fill_nx != FILL_W'(0)) && (fill_nx <= FILL_W'(2));
    keep_nx  = 2'b00;
    out_nx   = 16'h0000;
    if (valid_nx) begin
      if (fill_nx == FILL_W'(1)) begin
        keep_nx = 2'b01;
        out_nx  = {8'h00, data_nx[7:0]};
      end else begin
        keep_nx = 2'b11;
        out_nx  = data_nx[15:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state          <= IDLE;
      fmt_q          <= RAW8;
      fill           <= '0;
      data_q         <= '0;
      output_valid_o <= 1'b0;
      output_o       <= 16'h0000;
      output_keep_o  <= 2'b00;
      output_last_o  <= 1'b0;
    end else begin
      state          <= state_nx;
      fill           <= fill_nx;
      data_q         <= data_nx;
      output_valid_o <= valid_nx;
      output_o       <= out_nx;
      output_keep_o  <= keep_nx;
      output_last_o  <= last_nx;
      if (state == IDLE && accept) fmt_q <= fmt_in;
    end
  end

endmodule

// File: tb/tb_mipi_csi_tx_raw_packer_8b2lane.sv
// Directed bench for the 2-lane RAW packer: single-group vector table plus multi-cycle sequences.
module tb_mipi_csi_tx_raw_packer_8b2lane;
  logic        clk = 1'b0;
  logic        reset, pixel_valid, pixel_ready, pixel_last;
  logic [2:0]  packet_type;
  logic [63:0] pixel;
  logic        output_valid, output_ready, output_last;
  logic [15:0] output_w;
  logic [1:0]  output_keep;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [15:0] qw[$];
  logic [1:0]  qk[$];
  logic        ql[$];
  int          qc[$];
  int          acc[$];
  logic [7:0]  eb[$];
  bit          saw_last;

  typedef struct packed {
    logic [2:0]  t;
    logic [63:0] px;
    logic [1:0]  n;
    logic [47:0] w;
    logic [5:0]  k;
  } vec_t;

  vec_t vt[7];

  mipi_csi_tx_raw_packer_8b2lane #(.PIXEL_WIDTH(16)) dut (
    .clk_i(clk), .reset_i(reset), .packet_type_i(packet_type),
    .pixel_valid_i(pixel_valid), .pixel_ready_o(pixel_ready),
    .pixel_last_i(pixel_last), .pixel_i(pixel),
    .output_valid_o(output_valid), .output_ready_i(output_ready),
    .output_o(output_w), .output_keep_o(output_keep), .output_last_o(output_last)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (!reset && output_valid && output_ready) begin
      qw.push_back(output_w);
      qk.push_back(output_keep);
      ql.push_back(output_last);
      qc.push_back(cyc);
      if (output_last) saw_last = 1'b1;
    end
    if (!reset && pixel_valid && pixel_ready) acc.push_back(cyc);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_q();
    qw.delete(); qk.delete(); ql.delete(); qc.delete(); acc.delete(); eb.delete();
    saw_last = 1'b0;
  endtask

  task automatic send(input logic [2:0] t, input logic [63:0] px, input logic last);
    int  n = 0;
    bit  done = 1'b0;
    packet_type = t; pixel = px; pixel_last = last; pixel_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      done = pixel_ready;
      @(posedge clk); #1;
      n++;
      if (!done && n > 200) begin
        chk("send_timeout", 32'd1, 32'd0);
        done = 1'b1;
      end
    end
    pixel_valid = 1'b0;
  endtask

  task automatic wait_last(input string name);
    int n = 0;
    while (!saw_last && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(saw_last), 32'd1);
    @(posedge clk); #1;
  endtask

  // Reference byte order per format, taken straight from the wire-order tables.
  task automatic model(input int fmt, input logic [63:0] px);
    logic [15:0] s[4];
    for (int p = 0; p < 4; p++) s[p] = px[16*p +: 16];
    if (fmt == 10) begin
      for (int p = 0; p < 4; p++) eb.push_back(s[p][15:8]);
      eb.push_back({s[3][7:6], s[2][7:6], s[1][7:6], s[0][7:6]});
    end else if (fmt == 12) begin
      eb.push_back(s[0][15:8]); eb.push_back(s[1][15:8]);
      eb.push_back({s[1][7:4], s[0][7:4]});
      eb.push_back(s[2][15:8]); eb.push_back(s[3][15:8]);
      eb.push_back({s[3][7:4], s[2][7:4]});
    end else begin
      for (int p = 0; p < 4; p++) eb.push_back(s[p][15:8]);
    end
  endtask

  task automatic cmp_stream(input string name);
    logic [7:0] rb[$];
    int nlast = 0;
    for (int i = 0; i < qw.size(); i++) begin
      rb.push_back(qw[i][7:0]);
      if (qk[i][1]) rb.push_back(qw[i][15:8]);
      if (ql[i]) nlast++;
    end
    chk({name, "_bytes"}, 32'(rb.size()), 32'(eb.size()));
    for (int i = 0; i < rb.size() && i < eb.size(); i++)
      chk($sformatf("%s_b%0d", name, i), 32'(rb[i]), 32'(eb[i]));
    chk({name, "_nlast"}, 32'(nlast), 32'd1);
    if (ql.size() > 0) chk({name, "_final_last"}, 32'(ql[ql.size()-1]), 32'd1);
  endtask

  function automatic logic [63:0] px12(input int g);
    logic [63:0] r;
    for (int p = 0; p < 4; p++) r[16*p +: 16] = 16'(((g*293 + p*181 + 7) & 12'hFFF) << 4);
    return r;
  endfunction

  function automatic logic [63:0] px10(input int g);
    logic [63:0] r;
    for (int p = 0; p < 4; p++) r[16*p +: 16] = 16'(((g*157 + p*389 + 3) & 10'h3FF) << 6);
    return r;
  endfunction

  logic [15:0] w0;
  logic [1:0]  k0;

  initial begin
    vt[0] = '{3'h3, 64'hFFC0_00C0_0080_0040, 2'd3, 48'h00F9_FF00_0000, 6'b01_11_11};
    vt[1] = '{3'h4, 64'h7890_4560_1230_ABC0, 2'd3, 48'h9678_453C_12AB, 6'b11_11_11};
    vt[2] = '{3'h0, 64'h4400_3300_2200_1100, 2'd2, 48'h0000_4433_2211, 6'b00_11_11};
    vt[3] = '{3'h7, 64'h0000_FFFF_5A0F_A5F0, 2'd2, 48'h0000_00FF_5AA5, 6'b00_11_11};
    vt[4] = '{3'h3, 64'hFFC0_FFC0_FFC0_FFC0, 2'd3, 48'h00FF_FFFF_FFFF, 6'b01_11_11};
    vt[5] = '{3'h4, 64'h0000_FFF0_0000_FFF0, 2'd3, 48'h0F00_FF0F_00FF, 6'b11_11_11};
    vt[6] = '{3'h3, 64'hC000_3FC0_AA80_5540, 2'd3, 48'h0039_C03F_AA55, 6'b01_11_11};

    reset = 1'b1; pixel_valid = 1'b0; pixel_last = 1'b0; packet_type = 3'h0;
    pixel = '0; output_ready = 1'b1; saw_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pixel_ready", 32'(pixel_ready), 32'd0);
    chk("rst_valid", 32'(output_valid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 32'(output_valid), 32'd0);
    chk("post_rst_data", 32'(output_w), 32'd0);
    chk("post_rst_keep", 32'(output_keep), 32'd0);
    chk("post_rst_last", 32'(output_last), 32'd0);
    chk("post_rst_ready", 32'(pixel_ready), 32'd1);
    @(posedge clk); #1;

    // Single-group lines from the table.
    for (int v = 0; v < 7; v++) begin
      clear_q();
      send(vt[v].t, vt[v].px, 1'b1);
      wait_last($sformatf("vec%0d_done", v));
      chk($sformatf("vec%0d_nwords", v), 32'(qw.size()), 32'(vt[v].n));
      for (int i = 0; i < int'(vt[v].n) && i < qw.size(); i++) begin
        chk($sformatf("vec%0d_w%0d", v, i), 32'(qw[i]), 32'(vt[v].w[16*i +: 16]));
        chk($sformatf("vec%0d_k%0d", v, i), 32'(qk[i]), 32'(vt[v].k[2*i +: 2]));
        chk($sformatf("vec%0d_l%0d", v, i), 32'(ql[i]), 32'(i == int'(vt[v].n) - 1));
      end
    end

    // Back-to-back RAW10 at full rate.
    clear_q();
    for (int g = 0; g < 8; g++) begin
      model(10, px10(g));
      send(3'h3, px10(g), g == 7);
    end
    wait_last("b2b_done");
    chk("b2b_nwords", 32'(qw.size()), 32'd20);
    begin
      int gaps = 0;
      for (int i = 0; i + 1 < qc.size(); i++) if (qc[i+1] != qc[i] + 1) gaps++;
      chk("b2b_gaps", 32'(gaps), 32'd0);
    end
    chk("b2b_naccept", 32'(acc.size()), 32'd8);
    if (acc.size() == 8 && qc.size() > 0) begin
      chk("b2b_latency", 32'(qc[0] - acc[0]), 32'd1);
      for (int i = 0; i + 2 < 8; i++)
        chk($sformatf("b2b_rate%0d", i), 32'(acc[i+2] - acc[i]), 32'd5);
    end
    if (qk.size() > 0) chk("b2b_final_keep", 32'(qk[qk.size()-1]), 32'd3);
    cmp_stream("b2b");

    // RAW12 line with a 10-cycle downstream stall.
    clear_q();
    for (int g = 0; g < 6; g++) model(12, px12(g));
    fork
      begin
        for (int g = 0; g < 6; g++) send(3'h4, px12(g), g == 5);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        output_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          if (i == 0) begin
            w0 = output_w;
            k0 = output_keep;
            chk("stall_valid", 32'(output_valid), 32'd1);
          end else begin
            chk($sformatf("stall_hold%0d", i), {14'h0, output_keep, output_w}, {14'h0, k0, w0});
          end
          if (i == 9) chk("stall_backpressure", 32'(pixel_ready), 32'd0);
        end
        @(posedge clk); #1;
        output_ready = 1'b1;
      end
    join
    wait_last("stall_done");
    cmp_stream("stall");

    // Reset in PACK with six bytes buffered, then a clean RAW8 line.
    clear_q();
    output_ready = 1'b0;
    send(3'h4, px12(9), 1'b0);
    @(negedge clk);
    chk("pre_rst_valid", 32'(output_valid), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", 32'(pixel_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("after_rst_valid", 32'(output_valid), 32'd0);
    chk("after_rst_ready", 32'(pixel_ready), 32'd1);
    @(posedge clk); #1;
    clear_q();
    output_ready = 1'b1;
    send(3'h0, 64'h4400_3300_2200_1100, 1'b1);
    wait_last("rst_line_done");
    chk("rst_line_nwords", 32'(qw.size()), 32'd2);
    if (qw.size() == 2) begin
      chk("rst_line_w0", 32'(qw[0]), 32'h2211);
      chk("rst_line_w1", 32'(qw[1]), 32'h4433);
      chk("rst_line_l1", 32'(ql[1]), 32'd1);
    end

    // Type switch mid-line must not change the packing format.
    clear_q();
    model(10, px10(3));
    model(10, px10(4));
    send(3'h3, px10(3), 1'b0);
    send(3'h4, px10(4), 1'b1);
    wait_last("tchg_done");
    chk("tchg_nwords", 32'(qw.size()), 32'd5);
    if (qk.size() > 0) chk("tchg_final_keep", 32'(qk[qk.size()-1]), 32'd3);
    cmp_stream("tchg");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mipi_csi_tx_raw_packer_8b2lane.md
MIPI_CSI_TX_RAW_PACKER_8B2LANE -- requirements
Module: mipi_csi_tx_raw_packer_8b2lane

Interface
REQ-001 SHALL have parameter PIXEL_WIDTH, default 16, width of each MSB-aligned input pixel; legal range 12..16.
REQ-002 SHALL have port clk_i, input, 1 bit: single clock for all logic.
REQ-003 SHALL have port reset_i, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port packet_type_i, input, 3 bits: low 3 bits of the CSI data type; 3'h3 selects RAW10, 3'h4 selects RAW12, any other code selects RAW8.
REQ-005 SHALL have port pixel_valid_i, input, 1 bit: pixel group valid.
REQ-006 SHALL have port pixel_ready_o, output, 1 bit: pixel group accepted when high together with pixel_valid_i.
REQ-007 SHALL have port pixel_last_i, input, 1 bit: the group is the final group of the line.
REQ-008 SHALL have port pixel_i, input, 4*PIXEL_WIDTH bits: pixel 0 (first on wire) in the lowest slice; each pixel MSB-aligned.
REQ-009 SHALL have port output_valid_o, output, 1 bit: output word valid.
REQ-010 SHALL have port output_ready_i, input, 1 bit: downstream accepts the word when high together with output_valid_o.
REQ-011 SHALL have port output_o, output, 16 bits: lane 0 byte in [7:0] (earlier on wire), lane 1 byte in [15:8].
REQ-012 SHALL have port output_keep_o, output, 2 bits: byte enables for output_o.
REQ-013 SHALL have port output_last_o, output, 1 bit: the word holds the final byte of the line.

Function
REQ-014 SHALL pack each accepted group to bytes in wire order as follows:
- RAW8: P0[15:8], P1[15:8], P2[15:8], P3[15:8].
- RAW10: P0..P3 upper 8 bits, then {P3[1:0],P2[1:0],P1[1:0],P0[1:0]}.
- RAW12: P0 upper 8, P1 upper 8, {P1[3:0],P0[3:0]}, P2 upper 8, P3 upper 8, {P3[3:0],P2[3:0]}.
- Pixel bit k means bit k of the 10- or 12-bit value taken from the MSB-aligned field.
REQ-015 SHALL hold bytes in an 8-byte FIFO-ordered buffer with a 4-bit fill count. N = bytes per group: 4 for RAW8, 5 for RAW10, 6 for RAW12.
REQ-016 SHALL drive pixel_ready_o = !reset_i && state!=FLUSH && registered fill <= 8-N; a drain in the same cycle is not credited.
REQ-017 SHALL apply any accepted group and any output transfer in the same cycle; next fill = fill + N - bytes drained.
REQ-018 SHALL place the first byte of a group accepted in cycle C on output_o in cycle C+1 at the earliest.
REQ-019 SHALL assert output_valid_o when fill>=2, or when state==FLUSH and fill==1.
REQ-020 SHALL set output_keep_o to 2'b11, or to 2'b01 with output_o[15:8]=0 for a single-byte final word.
REQ-021 SHALL assert output_last_o only on the word that empties the buffer in FLUSH.
REQ-022 SHALL hold output_o, output_keep_o and output_last_o stable while output_valid_o=1 and output_ready_i=0.
REQ-023 SHALL implement the state machine IDLE -> PACK -> FLUSH -> IDLE:
- IDLE: an accepted group latches packet_type_i and moves to PACK, or to FLUSH if pixel_last_i=1.
- PACK: an accepted group with pixel_last_i=1 moves to FLUSH.
- FLUSH: the transfer of the output_last_o word moves to IDLE.
REQ-024 SHALL ignore packet_type_i outside IDLE; in IDLE it sets N for pixel_ready_o.
REQ-025 SHALL sustain full rate with output_ready_i=1: RAW8 one group/2 cycles, RAW10 2 groups/5 cycles, RAW12 one group/3 cycles.
REQ-026 SHALL never overflow or lose bytes under any output_ready_i pattern.

Reset
REQ-027 SHALL, while reset_i=1 at a clk_i edge, set state=IDLE, fill=0, buffer=0, output_valid_o=0, output_o=0, output_keep_o=0, output_last_o=0 and the latched type to RAW8; pixel_ready_o SHALL be 0 during reset.
REQ-028 SHALL discard a partially sent line on reset; the next line SHALL be packed correctly.

Verification
REQ-029 SHALL cover a single RAW10 group with last, values 0x001, 0x002, 0x003, 0x3FF (pixel_i slices 0x0040, 0x0080, 0x00C0, 0xFFC0) -> words 0x0000 (keep 11), 0xFF00 (keep 11), 0x00F9 (keep 01, last).
REQ-030 SHALL cover a single RAW12 group with last, values 0xABC, 0x123, 0x456, 0x789 -> words 0x12AB, 0x453C, 0x9678 (last, keep 11).
REQ-031 SHALL cover 8 back-to-back RAW10 groups with output_ready_i=1 -> 20 consecutive valid words, accept pattern 2 per 5 cycles, final word keep 11 with last.
REQ-032 SHALL cover output_ready_i=0 for 10 cycles mid RAW12 line -> output word stable, pixel_ready_o low once fill>2, byte stream identical to the no-stall case.
REQ-033 SHALL cover reset_i pulsed in PACK with fill=6 -> next cycle output_valid_o=0 and state IDLE; a following RAW8 line of 0x11,0x22,0x33,0x44 yields 0x2211, 0x4433 (last).
REQ-034 SHALL cover a packet_type_i change from 3'h3 to 3'h4 mid-line -> packing remains RAW10 until the line ends.
